// File: rtl/addr_decoder_n_if.sv
// Bus between a master, the address decoder and the slave it selects.
// The decoder sits on the slave modport.
interface addr_decoder_n_if #(
  parameter int ADDR_W     = 14,
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 3
);
  logic                  addr_valid;
  logic [ADDR_W-1:0]     inp_Addr;
  logic                  slave_done;
  logic                  addr_ack;
  logic [NUM_SLAVES-1:0] sel_s;
  logic [SEL_BITS-1:0]   sel_slave;
  logic                  busy;
  logic                  dec_err;
  logic                  timeout_err;

  modport master (
    output addr_valid, inp_Addr, slave_done,
    input  addr_ack, sel_s, sel_slave, busy, dec_err, timeout_err
  );

  modport slave (
    input  addr_valid, inp_Addr, slave_done,
    output addr_ack, sel_s, sel_slave, busy, dec_err, timeout_err
  );
endinterface

// File: rtl/addr_decoder_n.sv
// Address decoder: maps the address MSBs to a one-hot slave select, holds it
// for one transfer and aborts transfers whose slave never finishes.
module addr_decoder_n #(
  parameter int ADDR_W     = 14,
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  addr_decoder_n_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_SLAVES-1:0] r_sel_s, w_sel_s_nxt;
  logic [SEL_BITS-1:0]   r_sel_slave, w_sel_slave_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_dec_err, w_dec_err_nxt;
  logic                  r_to_err, w_to_err_nxt;

  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_mapped;

  // The shift consumes the whole address so no bit is left dangling.
  assign w_idx    = SEL_BITS'(bus.inp_Addr >> (ADDR_W - SEL_BITS));
  assign w_mapped = ({1'b0, w_idx} < (SEL_BITS + 1)'(NUM_SLAVES));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sel_s_nxt     = r_sel_s;
    w_sel_slave_nxt = r_sel_slave;
    w_ack_nxt       = 1'b0;
    w_dec_err_nxt   = 1'b0;
    w_to_err_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt       = '0;
        w_sel_s_nxt     = '0;
        w_sel_slave_nxt = '0;
        if (bus.addr_valid) begin
          w_ack_nxt = 1'b1;
          if (w_mapped) begin
            w_state_nxt     = ACTIVE;
            w_sel_s_nxt     = NUM_SLAVES'(1) << w_idx;
            w_sel_slave_nxt = w_idx;
          end else begin
            w_dec_err_nxt = 1'b1;
          end
        end
      end

      ACTIVE: begin
        // Completion is tested first so it wins over a coincident timeout.
        if (bus.slave_done || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_sel_s_nxt     = '0;
          w_sel_slave_nxt = '0;
          w_to_err_nxt    = !bus.slave_done;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sel_s     <= '0;
      r_sel_slave <= '0;
      r_ack       <= 1'b0;
      r_dec_err   <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel_s     <= w_sel_s_nxt;
      r_sel_slave <= w_sel_slave_nxt;
      r_ack       <= w_ack_nxt;
      r_dec_err   <= w_dec_err_nxt;
      r_to_err    <= w_to_err_nxt;
    end
  end

  assign bus.addr_ack    = r_ack;
  assign bus.sel_s       = r_sel_s;
  assign bus.sel_slave   = r_sel_slave;
  assign bus.busy        = (r_state == ACTIVE);
  assign bus.dec_err     = r_dec_err;
  assign bus.timeout_err = r_to_err;
endmodule
